// File: rtl/pipe_skid_reg.sv
// Registered pipeline stage with a 2-entry skid buffer between the data mux and
// the next datapath stage. in_ready is registered so out_ready never reaches it.
//
// state | meaning
// EMPTY | no word held, out_valid=0
// ONE   | main reg holds the head word
// FULL  | main holds head, skid holds the next word; in_ready=0
module pipe_skid_reg #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           count
);

    // Encoding equals occupancy, so count is the state register itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] main_q, main_d;
    logic [DATAWIDTH-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept, pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;
    assign count     = state_q;
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush wins over everything, including a word accepted this cycle.
        if (clr) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule
